// File: rtl/pe_mac_row.sv
// pe_mac_row: eight-lane signed MAC row. Each lane accumulates pe_data_i * fm_data
// over one NUM_TAPS read pass and hands the sums off through a valid/ready register.
// Define PE_MAC_SAT_EN for saturating accumulation and the sticky sat_flag output.
module pe_mac_row #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int NUM_TAPS = 16,
  parameter int WT_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_sop,
  input  logic [DATA_W-1:0] pe_data_0,
  input  logic [DATA_W-1:0] pe_data_1,
  input  logic [DATA_W-1:0] pe_data_2,
  input  logic [DATA_W-1:0] pe_data_3,
  input  logic [DATA_W-1:0] pe_data_4,
  input  logic [DATA_W-1:0] pe_data_5,
  input  logic [DATA_W-1:0] pe_data_6,
  input  logic [DATA_W-1:0] pe_data_7,
  input  logic [DATA_W-1:0] fm_data,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [ACC_W-1:0]  res_0,
  output logic [ACC_W-1:0]  res_1,
  output logic [ACC_W-1:0]  res_2,
  output logic [ACC_W-1:0]  res_3,
  output logic [ACC_W-1:0]  res_4,
  output logic [ACC_W-1:0]  res_5,
  output logic [ACC_W-1:0]  res_6,
  output logic [ACC_W-1:0]  res_7,
  output logic              busy,
  output logic              sop_err
`ifdef PE_MAC_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int LANES  = 8;
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(NUM_TAPS) + 1;
  localparam int WCNT_W = $clog2(WT_LAT) + 1;
  localparam logic [CNT_W-1:0]  TAP_LAST  = CNT_W'(NUM_TAPS - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((WT_LAT >= 2) ? (WT_LAT - 2) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_HOLD} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_tap_cnt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [ACC_W-1:0]  r_acc [LANES];
  logic [ACC_W-1:0]  r_res [LANES];
  logic              r_res_vld;
  logic              r_busy;
  logic              r_sop_err;
  logic [DATA_W-1:0] w_wt  [LANES];
  logic [ACC_W-1:0]  w_sum [LANES];
  logic              w_start;
`ifdef PE_MAC_SAT_EN
  logic              r_sat_flag;
  logic [LANES-1:0]  w_clamp;
`endif

  assign w_wt[0] = pe_data_0;
  assign w_wt[1] = pe_data_1;
  assign w_wt[2] = pe_data_2;
  assign w_wt[3] = pe_data_3;
  assign w_wt[4] = pe_data_4;
  assign w_wt[5] = pe_data_5;
  assign w_wt[6] = pe_data_6;
  assign w_wt[7] = pe_data_7;

  // A pass may start from IDLE, or straight out of HOLD in the handoff cycle.
  assign w_start = rd_sop && ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_rdy));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_ext;

    assign w_prod = PROD_W'($signed(w_wt[g])) * PROD_W'($signed(fm_data));
    assign w_ext  = ACC_W'(w_prod);
`ifdef PE_MAC_SAT_EN
    logic signed [ACC_W:0] w_wide;

    // One guard bit exposes overflow; clamp toward the sign of the true sum.
    assign w_wide     = (ACC_W+1)'($signed(r_acc[g])) + (ACC_W+1)'(w_ext);
    assign w_clamp[g] = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign w_sum[g]   = !w_clamp[g]   ? w_wide[ACC_W-1:0] :
                        w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                        {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign w_sum[g] = r_acc[g] + w_ext;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tap_cnt  <= '0;
      r_wait_cnt <= '0;
      r_res_vld  <= 1'b0;
      r_busy     <= 1'b0;
      r_sop_err  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= '0;
        r_res[i] <= '0;
      end
`ifdef PE_MAC_SAT_EN
      r_sat_flag <= 1'b0;
`endif
    end else begin
      r_sop_err <= rd_sop && !w_start && (r_state != S_IDLE);
      if (w_start) begin
        r_state    <= (WT_LAT >= 2) ? S_WAIT : S_ACC;
        r_tap_cnt  <= '0;
        r_wait_cnt <= '0;
        r_res_vld  <= 1'b0;
        r_busy     <= 1'b1;
        for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
`ifdef PE_MAC_SAT_EN
        r_sat_flag <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_WAIT: begin
            if (r_wait_cnt == WAIT_LAST) r_state <= S_ACC;
            else r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          end
          S_ACC: begin
            for (int i = 0; i < LANES; i++) r_acc[i] <= w_sum[i];
            r_tap_cnt <= r_tap_cnt + CNT_W'(1);
`ifdef PE_MAC_SAT_EN
            if (|w_clamp) r_sat_flag <= 1'b1;
`endif
            if (r_tap_cnt == TAP_LAST) begin
              for (int i = 0; i < LANES; i++) r_res[i] <= w_sum[i];
              r_state   <= S_HOLD;
              r_res_vld <= 1'b1;
              r_busy    <= 1'b0;
            end
          end
          S_HOLD: begin
            if (res_rdy) begin
              r_state   <= S_IDLE;
              r_res_vld <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign res_vld = r_res_vld;
  assign busy    = r_busy;
  assign sop_err = r_sop_err;
  assign res_0   = r_res[0];
  assign res_1   = r_res[1];
  assign res_2   = r_res[2];
  assign res_3   = r_res[3];
  assign res_4   = r_res[4];
  assign res_5   = r_res[5];
  assign res_6   = r_res[6];
  assign res_7   = r_res[7];
`ifdef PE_MAC_SAT_EN
  assign sat_flag = r_sat_flag;
`endif

endmodule

// File: tb/tb_pe_mac_row.sv
// tb_pe_mac_row: table vectors, hand sequences and random passes for pe_mac_row,
// checked against an exact-integer dot-product model; a second instance uses ACC_W=32.
`timescale 1ns/1ps
module tb_pe_mac_row;

  localparam int DW        = 16;
  localparam int AW        = 40;
  localparam int AW2       = 32;
  localparam int NT        = 16;
  localparam int WL        = 2;
  localparam int FIRST_VLD = WL + NT;
`ifdef PE_MAC_SAT_EN
  localparam logic [AW2-1:0] LANE6_32 = 32'h7FFFFFFF;
`else
  localparam logic [AW2-1:0] LANE6_32 = 32'hFFF00010;
`endif

  typedef struct packed {
    logic [7:0][15:0] w;
    logic [15:0]      f;
    int               rdyDelay;
    int               sopCycle;
    logic [7:0][39:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rd_sop, res_rdy;
  logic [DW-1:0]  pe [8];
  logic [DW-1:0]  fm_data;
  logic           vldA, busyA, errA, vldB, busyB, errB;
  logic [AW-1:0]  resA [8];
  logic [AW2-1:0] resB [8];
`ifdef PE_MAC_SAT_EN
  logic           satA, satB;
`endif

  logic signed [DW-1:0] wt  [NT][8];
  logic signed [DW-1:0] fmv [NT];
  logic [AW-1:0]  capA [8];
  logic [AW2-1:0] capB [8];
  bit             capSatB;
  vec_t           vecs [6];
  int             nChecks = 0;
  int             nErrors = 0;
  int             cyc = 0;

  always #5 clk = ~clk;

  pe_mac_row #(.DATA_W(DW), .ACC_W(AW), .NUM_TAPS(NT), .WT_LAT(WL)) dutA (
    .clk(clk), .rst(rst), .rd_sop(rd_sop),
    .pe_data_0(pe[0]), .pe_data_1(pe[1]), .pe_data_2(pe[2]), .pe_data_3(pe[3]),
    .pe_data_4(pe[4]), .pe_data_5(pe[5]), .pe_data_6(pe[6]), .pe_data_7(pe[7]),
    .fm_data(fm_data), .res_vld(vldA), .res_rdy(res_rdy),
    .res_0(resA[0]), .res_1(resA[1]), .res_2(resA[2]), .res_3(resA[3]),
    .res_4(resA[4]), .res_5(resA[5]), .res_6(resA[6]), .res_7(resA[7]),
    .busy(busyA), .sop_err(errA)
`ifdef PE_MAC_SAT_EN
    , .sat_flag(satA)
`endif
  );

  pe_mac_row #(.DATA_W(DW), .ACC_W(AW2), .NUM_TAPS(NT), .WT_LAT(WL)) dutB (
    .clk(clk), .rst(rst), .rd_sop(rd_sop),
    .pe_data_0(pe[0]), .pe_data_1(pe[1]), .pe_data_2(pe[2]), .pe_data_3(pe[3]),
    .pe_data_4(pe[4]), .pe_data_5(pe[5]), .pe_data_6(pe[6]), .pe_data_7(pe[7]),
    .fm_data(fm_data), .res_vld(vldB), .res_rdy(res_rdy),
    .res_0(resB[0]), .res_1(resB[1]), .res_2(resB[2]), .res_3(resB[3]),
    .res_4(resB[4]), .res_5(resB[5]), .res_6(resB[6]), .res_7(resB[7]),
    .busy(busyB), .sop_err(errB)
`ifdef PE_MAC_SAT_EN
    , .sat_flag(satB)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Exact dot product of one lane; with saturation each partial sum is clamped.
  function automatic logic [63:0] refLane(input int lane, input int accW, output bit clamped);
    longint acc, hi, lo;
    hi = (longint'(1) <<< (accW - 1)) - 1;
    lo = -hi - 1;
    acc = 0;
    clamped = 1'b0;
    for (int t = 0; t < NT; t++) begin
      acc += longint'(wt[t][lane]) * longint'(fmv[t]);
`ifdef PE_MAC_SAT_EN
      if (acc > hi) begin acc = hi; clamped = 1'b1; end
      else if (acc < lo) begin acc = lo; clamped = 1'b1; end
`endif
    end
    return acc;
  endfunction

  // Runs one pass from its rd_sop cycle (0) to its handoff cycle; chainIn means
  // cycle 0 was the previous pass's handoff, chainOut starts the next pass there.
  task automatic applyStimulus(input int rdyDelay, input int sopCycle, input bit chainIn, input bit chainOut);
    logic [AW-1:0]  expA [8];
    logic [AW2-1:0] expB [8];
    bit clA, clB, anyA, anyB;
    int hold;
    hold = FIRST_VLD + rdyDelay;
    anyA = 1'b0;
    anyB = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expA[i] = AW'(refLane(i, AW, clA));
      expB[i] = AW2'(refLane(i, AW2, clB));
      anyA |= clA;
      anyB |= clB;
    end
    for (int c = (chainIn ? 1 : 0); c <= hold; c++) begin
      nextCycle();
      rd_sop  = (c == 0) || (c == sopCycle) || (chainOut && (c == hold));
      res_rdy = (c < FIRST_VLD) ? 1'($urandom_range(1)) : (c >= hold);
      if (c >= WL && c < FIRST_VLD) begin
        for (int i = 0; i < 8; i++) pe[i] = wt[c-WL][i];
        fm_data = fmv[c-WL];
      end else begin
        for (int i = 0; i < 8; i++) pe[i] = DW'($urandom);
        fm_data = DW'($urandom);
      end
      checkOutput("busyA", 64'(busyA), 64'(c >= 1 && c < FIRST_VLD));
      checkOutput("busyB", 64'(busyB), 64'(c >= 1 && c < FIRST_VLD));
      checkOutput("res_vldA", 64'(vldA), 64'(c >= FIRST_VLD));
      checkOutput("res_vldB", 64'(vldB), 64'(c >= FIRST_VLD));
      checkOutput("sop_errA", 64'(errA), 64'(sopCycle >= 0 && c == sopCycle + 1));
      checkOutput("sop_errB", 64'(errB), 64'(sopCycle >= 0 && c == sopCycle + 1));
`ifdef PE_MAC_SAT_EN
      if (c == 1) checkOutput("sat_clearB", 64'(satB), 64'(0));
`endif
      if (c >= FIRST_VLD) begin
        for (int i = 0; i < 8; i++) begin
          checkOutput($sformatf("resA_%0d", i), 64'(resA[i]), 64'(expA[i]));
          checkOutput($sformatf("resB_%0d", i), 64'(resB[i]), 64'(expB[i]));
        end
`ifdef PE_MAC_SAT_EN
        checkOutput("sat_flagA", 64'(satA), 64'(anyA));
        checkOutput("sat_flagB", 64'(satB), 64'(anyB));
        if (c == hold) capSatB = satB;
`endif
        if (c == hold) begin
          for (int i = 0; i < 8; i++) begin
            capA[i] = resA[i];
            capB[i] = resB[i];
          end
        end
      end
    end
  endtask

  task automatic loadVec(input int v);
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < 8; i++) wt[t][i] = vecs[v].w[i];
      fmv[t] = vecs[v].f;
    end
  endtask

  function automatic logic [DW-1:0] rndWord();
    case ($urandom_range(3))
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] w1 [8];
    longint      e1 [8];
    bit          chain;
    w1 = '{16'hFFFD, 16'h0000, 16'h0001, 16'hFFFF, 16'h0064, 16'hFF9C, 16'h7FFF, 16'h8000};
    e1 = '{-64'sd1572816, 64'sd0, 64'sd524272, -64'sd524272,
           64'sd52427200, -64'sd52427200, 64'sd17178820624, -64'sd17179344896};
    for (int i = 0; i < 8; i++) begin
      vecs[0].w[i] = 16'(i + 1);          vecs[0].exp[i] = 40'(32 * (i + 1));
      vecs[1].w[i] = w1[i];               vecs[1].exp[i] = 40'(e1[i]);
      vecs[2].w[i] = 16'(7 * (i - 3));    vecs[2].exp[i] = 40'(-560 * (i - 3));
      vecs[3].w[i] = 16'(1000 * (i + 1)); vecs[3].exp[i] = 40'(-64'sd524288000 * (i + 1));
      vecs[4].w[i] = 16'(-(i * 4099));    vecs[4].exp[i] = 40'(-196752 * i);
      vecs[5].w[i] = 16'h8000;            vecs[5].exp[i] = 40'(64'sd17179869184);
    end
    vecs[0].f = 16'd2;    vecs[0].rdyDelay = 0; vecs[0].sopCycle = -1;
    vecs[1].f = 16'h7FFF; vecs[1].rdyDelay = 0; vecs[1].sopCycle = -1;
    vecs[2].f = 16'hFFFB; vecs[2].rdyDelay = 5; vecs[2].sopCycle = -1;
    vecs[3].f = 16'h8000; vecs[3].rdyDelay = 0; vecs[3].sopCycle = 5;
    vecs[4].f = 16'd3;    vecs[4].rdyDelay = 3; vecs[4].sopCycle = 19;
    vecs[5].f = 16'h8000; vecs[5].rdyDelay = 2; vecs[5].sopCycle = 1;

    rst = 1'b1; rd_sop = 1'b0; res_rdy = 1'b0; fm_data = '0;
    for (int i = 0; i < 8; i++) pe[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_vld", 64'(vldA), 64'(0));
    checkOutput("rst_busy", 64'(busyA), 64'(0));
    checkOutput("rst_err", 64'(errA), 64'(0));
    checkOutput("rst_res0", 64'(resA[0]), 64'(0));
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      loadVec(v);
      applyStimulus(vecs[v].rdyDelay, vecs[v].sopCycle, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("table%0d_res%0d", v, i), 64'(capA[i]), 64'(vecs[v].exp[i]));
      if (v == 1) begin
        checkOutput("acc32_lane6", 64'(capB[6]), 64'(LANE6_32));
`ifdef PE_MAC_SAT_EN
        checkOutput("acc32_sat", 64'(capSatB), 64'(1));
`endif
      end
    end

    // Back-to-back: vec 2 handed off in the same cycle vec 0 starts.
    loadVec(2);
    applyStimulus(0, -1, 1'b0, 1'b1);
    loadVec(0);
    applyStimulus(1, -1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("b2b_res%0d", i), 64'(capA[i]), 64'(vecs[0].exp[i]));

    // Reset in the middle of a pass: no result for it, outputs cleared at once.
    loadVec(4);
    for (int c = 0; c <= 10; c++) begin
      nextCycle();
      rd_sop = (c == 0);
      res_rdy = 1'b1;
      for (int i = 0; i < 8; i++) pe[i] = (c >= WL) ? wt[c-WL][i] : '0;
      fm_data = (c >= WL) ? fmv[c-WL] : '0;
    end
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 64'(busyA), 64'(0));
    checkOutput("midrst_vld", 64'(vldA), 64'(0));
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("midrst_resA%0d", i), 64'(resA[i]), 64'(0));
      checkOutput($sformatf("midrst_resB%0d", i), 64'(resB[i]), 64'(0));
    end
    nextCycle();
    rst = 1'b0;
    rd_sop = 1'b0;
    for (int c = 0; c < 20; c++) begin
      nextCycle();
      checkOutput("aborted_vld", 64'(vldA), 64'(0));
    end
    loadVec(0);
    applyStimulus(0, -1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("postrst_res%0d", i), 64'(capA[i]), 64'(vecs[0].exp[i]));

    // Random passes with random backpressure, stray rd_sop pulses and chaining.
    chain = 1'b0;
    for (int p = 0; p < 8; p++) begin
      int rd, sop;
      bit nxt;
      for (int t = 0; t < NT; t++) begin
        for (int i = 0; i < 8; i++) wt[t][i] = rndWord();
        fmv[t] = rndWord();
      end
      rd  = $urandom_range(3);
      sop = ($urandom_range(2) == 0) ? -1 : int'($urandom_range(FIRST_VLD + rd - 1, 1));
      nxt = (p < 7) ? 1'($urandom_range(1)) : 1'b0;
      applyStimulus(rd, sop, chain, nxt);
      chain = nxt;
    end
    nextCycle();
    rd_sop = 1'b0;
    checkOutput("final_idle_vld", 64'(vldA), 64'(0));
    checkOutput("final_idle_busy", 64'(busyA), 64'(0));

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pe_mac_row.md
Name: pe_mac_row

Overview:
- Downstream consumer of the weight buffer's eight 16-bit per-PE weight lanes (pe_data_0..7).
- Computes eight signed dot products, one per lane, over a NUM_TAPS-long read pass started by rd_sop. In each product the lane weight is multiplied by a broadcast feature word fm_data.
- Results are registered and handed off through a valid/ready handshake to the output/requant stage.
- Sits between the weight RAM readout and the result collector in the PE array.

Parameters:
- DATA_W, 16, width of each weight lane and of fm_data (signed two's complement).
- ACC_W, 40, accumulator and result width; must be >= 2*DATA_W.
- NUM_TAPS, 16, taps per pass; equals the weight RAM depth; range 1..256.
- WT_LAT, 2, cycles from the rd_sop sample to the first valid tap on pe_data_*/fm_data; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_sop  in  1  pass-start pulse; the same pulse that starts the weight RAM readout.
- pe_data_0..pe_data_7  in  DATA_W each  per-lane weight tap.
- fm_data  in  DATA_W  feature tap broadcast to all lanes, aligned with the weights.
- res_vld  out  1  result valid.
- res_rdy  in  1  downstream ready.
- res_0..res_7  out  ACC_W each  per-lane dot-product result.
- busy  out  1  high in WAIT or ACC.
- sop_err  out  1  one-cycle pulse when rd_sop is dropped.
- sat_flag  out  1  sticky saturation indicator; only present with PE_MAC_SAT_EN.

Behaviour:
- Reset: asynchronous, active-high. While rst is high: state=IDLE; all accumulators, res_0..7, counters, res_vld, busy, sop_err and sat_flag are 0. Assertion mid-pass aborts the pass with no result.
- States and transitions:
  - IDLE: on rd_sop, go to WAIT if WT_LAT>=2, else go to ACC. Clear all accumulators and tap_cnt on entry.
  - WAIT: count WT_LAT-1 cycles, then go to ACC.
  - ACC: tap_cnt 0..NUM_TAPS-1. Each cycle, acc_i += sext(pe_data_i * fm_data); the product is a signed 2*DATA_W-bit value sign-extended to ACC_W. On the last tap, the final sums (including that tap) load into res_0..7 and the block goes to HOLD.
  - HOLD: res_vld=1; res_* stable. On res_vld&&res_rdy, go to IDLE; if rd_sop is also high that cycle, go directly to WAIT/ACC (back-to-back pass, accumulators cleared).
- Timing: rd_sop sampled at cycle 0 -> taps consumed at cycles WT_LAT..WT_LAT+NUM_TAPS-1 -> res_vld high from cycle WT_LAT+NUM_TAPS. With defaults: taps at cycles 2..17, res_vld at cycle 18.
- Handshake:
  - res_vld, once high, stays high and res_* stay unchanged until res_rdy is sampled high.
  - res_vld deasserts the cycle after the handoff unless a new result is ready in that same cycle (not possible, since minimum pass length is >= 2).
  - res_rdy is ignored while res_vld=0.
- sop_err: rd_sop seen in WAIT or ACC, or in HOLD without res_rdy, is ignored. sop_err pulses high for 1 cycle; state and accumulators are unaffected.
- Arithmetic, default build: accumulation wraps modulo 2^ACC_W.
- tap_cnt: width clog2(NUM_TAPS)+1; no wrap inside a pass.
- busy: registered copy of (state==WAIT || state==ACC).
- Input alignment: pe_data_* and fm_data are not registered inside this block. The caller guarantees alignment at the tap cycles.

Optional Feature:
- Macro: PE_MAC_SAT_EN.
- Defined:
  - Each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1] instead of wrapping.
  - sat_flag port exists; it is set when any lane clamps and cleared only by rst or by the next pass start.
- Undefined:
  - Wrap-around arithmetic.
  - sat_flag port absent.

Test Plan:
- Defaults; rd_sop at cycle 0; pe_data_i = i+1, fm_data = 2 for all 16 taps; res_rdy=1 -> res_i = 32*(i+1) (res_7 = 256); res_vld high exactly at cycle 18 for 1 cycle; busy high cycles 1..17.
- Signed: lane 0 weight = -3 (0xFFFD), fm_data = 0x7FFF for 16 taps -> res_0 = -1572816 sign-extended to 40 bits.
- Backpressure: res_rdy=0 for 5 cycles after res_vld -> res_vld and res_* hold stable; res_rdy=1 at cycle 23 -> res_vld=0 at cycle 24.
- Back-to-back: rd_sop and res_rdy both high in the handoff cycle -> second pass starts with no idle cycle and its results are not contaminated by pass 1. Extra rd_sop sent at cycle 5 -> sop_err pulses at cycle 6 and the results are unchanged.
- Reset mid-pass: rst high at cycle 10 -> all outputs 0 immediately; res_vld never asserts for the aborted pass; the next rd_sop gives a correct result.
- PE_MAC_SAT_EN with ACC_W=32: weight 0x7FFF, fm_data 0x7FFF, 16 taps -> res = 0x7FFFFFFF and sat_flag=1. Without the macro, the same stimulus gives the wrapped value 0xFFF00010.
